instr_mem_resp: RTL

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

---
 rtl/instr_mem_pkg.sv | 16 +
 rtl/fetch_resp_fifo2.sv | 69 ++++++
 rtl/instr_mem_resp.sv | 101 ++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package instr_mem_pkg;

    // Instruction returned for any faulting fetch (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default instruction memory size in 32-bit words.
    localparam int DEPTH_DEFAULT = 256;

    // One queued fetch response.
    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } fetch_resp_t;

endpackage

// File: rtl/fetch_resp_fifo2.sv
// Two-entry in-order response FIFO with synchronous flush.
// Entry storage is not reset; validity is tracked by the count alone.
module fetch_resp_fifo2
    import instr_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        push_i,
    input  fetch_resp_t push_data_i,
    input  logic        pop_i,
    output logic        valid_o,
    output fetch_resp_t head_o,
    output logic [1:0]  count_o
);

    fetch_resp_t entries_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    // Next-state pointers and count; a flush clears everything and wins over push/pop.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && !flush_i && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            if (do_push && !do_pop) begin
                count_d = count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign head_o  = entries_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction memory with a one-cycle read stage feeding a two-entry
// response FIFO. Fetch requests are throttled so that queued plus in-flight
// responses never exceed the FIFO depth; a loader port writes the array.
module instr_mem_resp
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_addr_i,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [31:0]   resp_instr_o,
    output logic          resp_fault_o,
    input  logic          flush_i,
    input  logic          ld_en_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_data_i,
    output logic          busy_o
);

    logic [31:0]   mem [DEPTH];
    logic          inflight_q, inflight_d;
    logic [AW-1:0] rd_idx_q;
    logic          rd_fault_q;
    logic [1:0]    fifo_count;
    logic          fifo_valid;
    logic          accept;
    logic          pop;
    fetch_resp_t   rd_resp;
    fetch_resp_t   head;

    // Misaligned or out-of-range PCs fault instead of reading memory.
    function automatic logic addr_faults(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
    endfunction

    // Same-cycle pops deliberately do not free a slot, keeping ready off the pop path.
    assign req_ready_o = !flush_i && !ld_en_i &&
                         ((fifo_count + {1'b0, inflight_q}) < 2'd2);
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = fifo_valid && resp_ready_i;

    // The read stage always completes in one cycle, so inflight simply follows accept.
    always_comb begin
        inflight_d = accept;
    end

    // In-flight flag with asynchronous reset; reset drops any pending read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Latch the word index and fault flag of the accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_idx_q   <= req_addr_i[AW+1:2];
            rd_fault_q <= addr_faults(req_addr_i);
        end
    end

    // Loader write port; the array is never reset.
    always_ff @(posedge clk) begin
        if (ld_en_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    // Read happens before the edge that pushes it, so a same-edge load sees old data.
    always_comb begin
        rd_resp.fault = rd_fault_q;
        rd_resp.instr = rd_fault_q ? NOP_INSTR : mem[rd_idx_q];
    end

    fetch_resp_fifo2 u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .push_i      (inflight_q),
        .push_data_i (rd_resp),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Outputs are forced to zero when nothing is queued, so reset clears them.
    assign resp_valid_o = fifo_valid;
    assign resp_instr_o = fifo_valid ? head.instr : 32'h0;
    assign resp_fault_o = fifo_valid && head.fault;
    assign busy_o       = inflight_q || (fifo_count != 2'd0);

endmodule
